load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit between the RV32I core's datapath and a variable-latency 32-bit data-memory bus. It accepts one access per request using the core's own store/load size codes. It splits misaligned accesses into two word beats and byte-steers and merges the data. It sign- or zero-extends load results and stalls the core until the access completes.

## Interface
- MAX_WAIT, 255: bus-wait cycles per beat before abort; range 1..255.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  access request from the core; sampled only in IDLE.
- mem_write  in  1  1 = store, 0 = load.
- store  in  2  00 sb, 01 sh, 10 sw, 11 treated as sw.
- load  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others treated as lw.
- addr  in  32  byte address, captured at accept.
- wdata  in  32  store data, LSB-aligned, captured at accept.
- busy  out  1  core stall.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid while done=1.
- err  out  1  timeout flag; pulses with done.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  word address; bits [1:0] always 0.
- bus_be  out  4  byte enables; bit i enables byte lane i.
- bus_wdata  out  32  lane-steered write data.
- bus_ack  in  1  beat complete; bus_rdata is valid in the same cycle.
- bus_rdata  in  32  read data.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - start=1 captures mem_write, store/load, addr, wdata.
  - Next state is BEAT0.
- Access size: 1 for byte codes, 2 for half codes, 4 for word codes; mask = (1<<size)-1. Offset = addr[1:0].
- Split condition: offset+size>4.
- BEAT0 bus fields:
  - bus_addr = {addr[31:2],2'b00}.
  - bus_be = (mask<<off)[3:0].
  - bus_wdata = wdata<<(8*off).
- BEAT1 bus fields:
  - bus_addr = BEAT0 address + 4, wrapping modulo 2^32.
  - bus_be = mask>>(4-off).
  - bus_wdata = wdata>>(8*(4-off)).
- Transitions out of BEAT0 on bus_ack: to BEAT1 if split, otherwise to DONE.
- Transition out of BEAT1 on bus_ack: to DONE.
- DONE: done=1, then IDLE unconditionally. start is ignored in DONE because it still belongs to the completing instruction.
- Load merge:
  - raw = beat0_rdata>>(8*off), OR (beat1_rdata<<(8*(4-off))) when split.
  - Then take the low `size` bytes.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- Stores: rdata=0 at done.
- Timeout:
  - A per-beat wait counter counts cycles in BEAT0/BEAT1 with bus_ack=0; it clears at beat entry.
  - When MAX_WAIT such cycles have elapsed, the FSM goes to DONE with err=1 and rdata=0, skipping any remaining beat.
  - A timed-out store may have partially written; this is not reported separately.
- Reset (any state):
  - Next state is IDLE, counter 0, all outputs 0.
  - A bus beat in flight is abandoned.

## Timing
- Reset values: busy=0, done=0, err=0, rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
- busy = (IDLE & start) | BEAT0 | BEAT1. This is the only combinational output, so the core stalls in the request cycle itself.
- bus_req=1 exactly in BEAT0/BEAT1.
- All bus fields are registered and held stable until the cycle bus_ack=1.
- Between split beats, bus_req stays high and the address/enables/data change in the cycle after the BEAT0 ack.
- Latency with start at cycle T and bus_ack in every beat's first cycle:
  - Aligned access: BEAT0 at T+1, done at T+2.
  - Split access: BEAT1 at T+2, done at T+3.
- Each wait cycle adds 1 cycle of latency.
- Timeout: with no ack, bus_req is high for MAX_WAIT cycles in the beat, and DONE is the next cycle.
- done, err and rdata are registered and valid only in the DONE cycle; busy=0 in DONE.
- bus_ack outside BEAT0/BEAT1 is ignored.

## Test plan
- Aligned word store: sw addr 0x100, wdata 0xDEADBEEF, ack 2 cycles late -> one beat with bus_addr 0x100, be 1111, bus_wdata 0xDEADBEEF, bus_we=1; done at T+4; busy high T..T+3.
- Byte load extension: lb addr 0x203, bus_rdata 0x80112233 -> bus_be 1000, rdata 0xFFFFFF80. lbu at the same address and data -> rdata 0x00000080.
- Misaligned half store: sh addr 0x103, wdata 0x0000A55A.
  - Beat 0: 0x100, be 1000, byte3=0x5A.
  - Beat 1: 0x104, be 0001, byte0=0xA5.
  - done at T+3 with zero-wait acks.
- Misaligned word load: lw addr 0x102, memory 0x44332211 @0x100 and 0x88776655 @0x104 -> rdata 0x66554433. lh addr 0x101 on 0x44332211 -> rdata 0x00003322.
- Timeout: MAX_WAIT=4, lw with bus_ack held 0 -> bus_req high T+1..T+4; done=err=1 at T+5, rdata 0; busy 0 at T+5.
- Wrap and reset:
  - lw addr 0xFFFFFFFE -> beat 0 at 0xFFFFFFFC, beat 1 at 0x00000000.
  - reset=0 during BEAT1 -> next cycle IDLE, bus_req=0, busy=0, no done pulse.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: splits misaligned accesses into two word
// beats on a variable-latency bus, steers lanes and extends load results.
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_write,
    input  logic [1:0]  store,
    input  logic [2:0]  load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t      state, state_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic        we_q, we_n, sext_q, sext_n, split_q, split_n;
    logic [2:0]  size_q, size_n;
    logic [1:0]  off_q, off_n;
    logic [3:0]  be1_q, be1_n;
    logic [31:0] wd1_q, wd1_n, raw0_q, raw0_n;
    logic        done_n, err_n, bus_req_n, bus_we_n;
    logic [31:0] rdata_n, bus_addr_n, bus_wdata_n;
    logic [3:0]  bus_be_n;

    logic [2:0]  acc_size;
    logic        acc_sext, acc_split;
    logic [3:0]  acc_mask;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;

    // Right-align the byte pair, keep the access size, then extend.
    function automatic logic [31:0] extend(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [2:0] size, input logic sext);
        logic [31:0] raw;
        raw = 32'(pair >> {off, 3'b000});
        case (size)
            3'd1:    return sext ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
            3'd2:    return sext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Request decode; the upper halves of the widened lane vectors form beat 1.
    always_comb begin
        acc_size = 3'd4;
        acc_sext = 1'b0;
        if (mem_write) begin
            case (store)
                2'b00:   acc_size = 3'd1;
                2'b01:   acc_size = 3'd2;
                default: acc_size = 3'd4;
            endcase
        end else begin
            case (load)
                3'b000:  begin acc_size = 3'd1; acc_sext = 1'b1; end
                3'b001:  begin acc_size = 3'd2; acc_sext = 1'b1; end
                3'b100:  acc_size = 3'd1;
                3'b101:  acc_size = 3'd2;
                default: acc_size = 3'd4;
            endcase
        end
        case (acc_size)
            3'd1:    acc_mask = 4'b0001;
            3'd2:    acc_mask = 4'b0011;
            default: acc_mask = 4'b1111;
        endcase
        acc_split = (3'(addr[1:0]) + acc_size) > 3'd4;
        be_wide   = 8'(acc_mask) << addr[1:0];
        wd_wide   = 64'(wdata) << {addr[1:0], 3'b000};
    end

    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        we_n        = we_q;
        sext_n      = sext_q;
        split_n     = split_q;
        size_n      = size_q;
        off_n       = off_q;
        be1_n       = be1_q;
        wd1_n       = wd1_q;
        raw0_n      = raw0_q;
        done_n      = 1'b0;
        err_n       = 1'b0;
        rdata_n     = 32'd0;
        bus_req_n   = bus_req;
        bus_we_n    = bus_we;
        bus_addr_n  = bus_addr;
        bus_be_n    = bus_be;
        bus_wdata_n = bus_wdata;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = BEAT0;
                    wait_cnt_n  = '0;
                    we_n        = mem_write;
                    sext_n      = acc_sext;
                    split_n     = acc_split;
                    size_n      = acc_size;
                    off_n       = addr[1:0];
                    be1_n       = be_wide[7:4];
                    wd1_n       = wd_wide[63:32];
                    bus_req_n   = 1'b1;
                    bus_we_n    = mem_write;
                    bus_addr_n  = {addr[31:2], 2'b00};
                    bus_be_n    = be_wide[3:0];
                    bus_wdata_n = wd_wide[31:0];
                end
            end
            BEAT0, BEAT1: begin
                if (bus_ack && state == BEAT0 && split_q) begin
                    state_n     = BEAT1;
                    wait_cnt_n  = '0;
                    raw0_n      = bus_rdata;
                    bus_addr_n  = bus_addr + 32'd4;
                    bus_be_n    = be1_q;
                    bus_wdata_n = wd1_q;
                end else if (bus_ack || 32'(wait_cnt) == MAX_WAIT - 1) begin
                    state_n     = DONE;
                    done_n      = 1'b1;
                    err_n       = !bus_ack;
                    bus_req_n   = 1'b0;
                    bus_we_n    = 1'b0;
                    bus_addr_n  = 32'd0;
                    bus_be_n    = 4'd0;
                    bus_wdata_n = 32'd0;
                    if (bus_ack && !we_q) begin
                        rdata_n = extend((state == BEAT1) ? {bus_rdata, raw0_q} : {32'd0, bus_rdata},
                                         off_q, size_q, sext_q);
                    end
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            we_q      <= 1'b0;
            sext_q    <= 1'b0;
            split_q   <= 1'b0;
            size_q    <= 3'd0;
            off_q     <= 2'd0;
            be1_q     <= 4'd0;
            wd1_q     <= 32'd0;
            raw0_q    <= 32'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            we_q      <= we_n;
            sext_q    <= sext_n;
            split_q   <= split_n;
            size_q    <= size_n;
            off_q     <= off_n;
            be1_q     <= be1_n;
            wd1_q     <= wd1_n;
            raw0_q    <= raw0_n;
            done      <= done_n;
            err       <= err_n;
            rdata     <= rdata_n;
            bus_req   <= bus_req_n;
            bus_we    <= bus_we_n;
            bus_addr  <= bus_addr_n;
            bus_be    <= bus_be_n;
            bus_wdata <= bus_wdata_n;
        end
    end

    // Stall combinationally in the request cycle so the core holds its operands.
    assign busy = (state == IDLE && start) || state == BEAT0 || state == BEAT1;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected bus beats and
// results; a negedge monitor compares them whenever the DUT presents them.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, mem_write = 1'b0;
    logic [1:0]  store = 2'b0;
    logic [2:0]  load = 3'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        busy, done, err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    load_store_unit #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
        .store(store), .load(load), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } beat_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } res_t;

    beat_t beat_q[$];
    res_t  res_q[$];
    int    cyc = 0;
    int    checks = 0, failures = 0;
    int    busy_lo = -1, busy_hi = -2;
    int    req_cycles = 0;
    bit    mon_en = 1'b0, free_bus = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
        beat_t b;
        b.a = a; b.be = be; b.we = we; b.wd = wd;
        beat_q.push_back(b);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && res_q.size() != 0; i++) step();
        if (res_q.size() != 0) begin
            check("done_timeout", 72'(res_q.size()), 72'(0));
            res_q.delete();
        end
        check("beats_left", 72'(beat_q.size()), 72'(0));
        beat_q.delete();
        step();
    endtask

    // One access: nb acked beats with w0/w1 wait cycles; nb=0 never acks.
    task automatic run(input logic we, input logic [1:0] st, input logic [2:0] ld,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int nb, input int w0, input logic [31:0] rd0,
                       input int w1, input logic [31:0] rd1,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
        res_t r;
        int   t;
        t = cyc;
        r.rd = exp_rd; r.err = exp_err; r.cyc = t + lat;
        res_q.push_back(r);
        busy_lo = t;
        busy_hi = t + lat - 1;
        start = 1'b1; mem_write = we; store = st; load = ld; addr = a; wdata = wd;
        step();
        start = 1'b0; mem_write = ~we; store = ~st; load = ~ld; addr = ~a; wdata = ~wd;
        if (nb >= 1) begin
            repeat (w0) step();
            bus_ack = 1'b1; bus_rdata = rd0;
            step();
            bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
        end
        if (nb == 2) begin
            repeat (w1) step();
            bus_ack = 1'b1; bus_rdata = rd1;
            step();
            bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
        end
        wait_idle();
    endtask

    // Monitor: busy window, bus beats against the beat queue, results against the result queue.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 72'(busy), 72'(cyc >= busy_lo && cyc <= busy_hi));
            if (bus_req) begin
                req_cycles++;
                if (beat_q.size() > 0) begin
                    check("beat", 72'({bus_addr, bus_be, bus_we, bus_wdata}), 72'(beat_q[0]));
                    if (bus_ack) void'(beat_q.pop_front());
                end else if (!free_bus) begin
                    check("stray_bus_req", 72'(bus_req), 72'(0));
                end
            end
            if (done) begin
                if (res_q.size() > 0) begin
                    res_t r;
                    r = res_q.pop_front();
                    check("rdata", 72'(rdata), 72'(r.rd));
                    check("err", 72'(err), 72'(r.err));
                    check("done_cycle", 72'(cyc), 72'(r.cyc));
                end else begin
                    check("unexpected_done", 72'(done), 72'(0));
                end
            end else if (err || rdata != 32'd0) begin
                check("outs_without_done", 72'({err, rdata}), 72'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        step();
        step();
        @(negedge clk);
        check("reset_outs", 72'({busy, done, err, rdata, bus_req, bus_we}), 72'(0));
        check("reset_bus", 72'({bus_addr, bus_be, bus_wdata}), 72'(0));
        step();
        reset = 1'b1;
        mon_en = 1'b1;
        step();

        // Aligned sw, two wait cycles
        beat(32'h100, 4'b1111, 1'b1, 32'hDEAD_BEEF);
        run(1'b1, 2'b10, 3'b000, 32'h100, 32'hDEAD_BEEF, 1, 2, 32'h1234_5678, 0, 0, 32'h0, 1'b0, 4);
        // lb / lbu on the top lane
        beat(32'h200, 4'b1000, 1'b0, 32'h0);
        run(1'b0, 2'b00, 3'b000, 32'h203, 32'h0, 1, 0, 32'h8011_2233, 0, 0, 32'hFFFF_FF80, 1'b0, 2);
        beat(32'h200, 4'b1000, 1'b0, 32'h0);
        run(1'b0, 2'b00, 3'b100, 32'h203, 32'h0, 1, 0, 32'h8011_2233, 0, 0, 32'h0000_0080, 1'b0, 2);
        // Misaligned sh across the word boundary
        beat(32'h100, 4'b1000, 1'b1, 32'h5A00_0000);
        beat(32'h104, 4'b0001, 1'b1, 32'h0000_00A5);
        run(1'b1, 2'b01, 3'b000, 32'h103, 32'h0000_A55A, 2, 0, 32'h0, 0, 32'h0, 32'h0, 1'b0, 3);
        // Misaligned lw, then in-word lh
        beat(32'h100, 4'b1100, 1'b0, 32'h0);
        beat(32'h104, 4'b0011, 1'b0, 32'h0);
        run(1'b0, 2'b00, 3'b010, 32'h102, 32'h0, 2, 0, 32'h4433_2211, 0, 32'h8877_6655, 32'h6655_4433, 1'b0, 3);
        beat(32'h100, 4'b0110, 1'b0, 32'h0);
        run(1'b0, 2'b00, 3'b001, 32'h101, 32'h0, 1, 0, 32'h4433_2211, 0, 0, 32'h0000_3322, 1'b0, 2);
        // lh / lhu with the sign bit set
        beat(32'h100, 4'b0011, 1'b0, 32'h0);
        run(1'b0, 2'b00, 3'b001, 32'h100, 32'h0, 1, 0, 32'h1234_8001, 0, 0, 32'hFFFF_8001, 1'b0, 2);
        beat(32'h100, 4'b0011, 1'b0, 32'h0);
        run(1'b0, 2'b00, 3'b101, 32'h100, 32'h0, 1, 0, 32'h1234_8001, 0, 0, 32'h0000_8001, 1'b0, 2);
        // Reserved load code behaves as lw, one wait cycle
        beat(32'h200, 4'b1111, 1'b0, 32'h0);
        run(1'b0, 2'b00, 3'b111, 32'h200, 32'h0, 1, 1, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 1'b0, 3);
        // sb on lane 1
        beat(32'h100, 4'b0010, 1'b1, 32'hFFFF_AB00);
        run(1'b1, 2'b00, 3'b000, 32'h101, 32'hFFFF_FFAB, 1, 0, 32'h0, 0, 0, 32'h0, 1'b0, 2);
        // Store code 11 as sw, misaligned, wait in beat 1
        beat(32'h200, 4'b1110, 1'b1, 32'h3456_7800);
        beat(32'h204, 4'b0001, 1'b1, 32'h0000_0012);
        run(1'b1, 2'b11, 3'b000, 32'h201, 32'h1234_5678, 2, 0, 32'h0, 1, 32'h0, 32'h0, 1'b0, 4);
        // Timeout with MAX_WAIT=4
        free_bus = 1'b1;
        req_cycles = 0;
        run(1'b0, 2'b00, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 1'b1, 5);
        check("timeout_req_cycles", 72'(req_cycles), 72'(4));
        free_bus = 1'b0;
        // Address wrap between beats
        beat(32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0);
        beat(32'h0000_0000, 4'b0011, 1'b0, 32'h0);
        run(1'b0, 2'b00, 3'b010, 32'hFFFF_FFFE, 32'h0, 2, 0, 32'hA1B2_C3D4, 0, 32'h1122_3344, 32'h3344_A1B2, 1'b0, 3);

        // Reset while in BEAT1: no done pulse, bus released
        free_bus = 1'b1;
        beat(32'h104, 4'b1100, 1'b0, 32'h0);
        t = cyc;
        busy_lo = t;
        busy_hi = t + 2;
        start = 1'b1; mem_write = 1'b0; load = 3'b010; addr = 32'h106; wdata = 32'h0;
        step();
        start = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0000_0001;
        step();
        bus_ack = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rst_bus_req", 72'(bus_req), 72'(0));
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_done", 72'({done, err, rdata}), 72'(0));
        check("rst_bus_fields", 72'({bus_we, bus_addr, bus_be, bus_wdata}), 72'(0));
        step();
        step();
        free_bus = 1'b0;
        check("rst_beats_left", 72'(beat_q.size()), 72'(0));

        // Recovery after reset
        beat(32'h0, 4'b0001, 1'b0, 32'h0);
        run(1'b0, 2'b00, 3'b100, 32'h0, 32'h0, 1, 0, 32'h0000_00FF, 0, 0, 32'h0000_00FF, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
